// File: rtl/clk_div_switch_pkg.sv
// Shared clocking package for the programmable clock divider.
// Holds the FSM state encoding and the default divide value.
package clk_div_switch_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  // Divide value loaded at reset: clk_out = clk/4.
  localparam int DEF_DIV_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_HIGH = HIGH,
    ST_LOW  = LOW
  } state_t;

endpackage

// File: rtl/clk_div_switch_if.sv
// Control/status bundle of the clock divider.
//   en         run request (level)
//   div_val    requested half-period minus 1
//   div_load   single-cycle strobe capturing div_val
//   clk_out    divided clock
//   rise_stb   strobe on the cycle clk_out goes 0->1
//   fall_stb   strobe on the cycle clk_out goes 1->0
//   div_busy   captured value pending, not yet applied
//   div_done   pulse when the pending value becomes active
//   active_div divide value currently in use
// master: the controlling side; slave: the divider.
interface clk_div_switch_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             clk_out;
  logic             rise_stb;
  logic             fall_stb;
  logic             div_busy;
  logic             div_done;
  logic [CNT_W-1:0] active_div;

  modport master (
    output en, div_val, div_load,
    input  clk_out, rise_stb, fall_stb, div_busy, div_done, active_div
  );

  modport slave (
    input  en, div_val, div_load,
    output clk_out, rise_stb, fall_stb, div_busy, div_done, active_div
  );
endinterface

// File: rtl/clk_div_switch_div_half_cnt.sv
// Half-period counter for the clock divider.
//   clk     reference clock
//   rst_n   asynchronous active-low reset
//   clr_i   restart the count at 0 on the next edge (else count up)
//   limit_i terminal value (active divide value)
//   tc_o    count has reached limit_i
module div_half_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The owner clears on terminal count, so the count never passes limit_i
  // and never wraps.
  assign cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);
  assign tc_o  = (cnt_q == limit_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_switch.sv
// Glitch-free programmable clock divider. clk_out has period
// 2*(active_div+1) clk cycles at 50% duty. Divide changes requested while
// running are held pending and applied only at a period boundary, so no
// truncated phase is ever produced. All outputs are registered.
//   clk    reference clock
//   rst_n  asynchronous active-low reset
//   bus    control/status bundle (slave side), see clk_div_switch_if
module clk_div_switch
  import clk_div_switch_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  clk_div_switch_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] active_div_q, active_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             cnt_clr;
  logic             cnt_tc;

  div_half_cnt #(
    .CNT_W (CNT_W)
  ) u_half_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .limit_i (active_div_q),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    active_div_d = active_div_q;
    pend_d       = pend_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cnt_clr      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.div_load) begin
          active_div_d = bus.div_val;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else if (busy_q) begin
          // A load that landed on the final boundary before stopping is
          // still pending; nothing is running, so apply it now.
          active_div_d = pend_q;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end
        if (bus.en) begin
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        cnt_clr = cnt_tc;
        if (cnt_tc) begin
          state_d = ST_LOW;
        end
        if (bus.div_load) begin
          pend_d = bus.div_val;
          busy_d = 1'b1;
        end
      end

      ST_LOW: begin
        cnt_clr = cnt_tc;
        if (cnt_tc) begin
          if (busy_q) begin
            active_div_d = pend_q;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end
          state_d = bus.en ? ST_HIGH : ST_IDLE;
        end
        // A load on the boundary cycle goes to pend and waits for the next
        // boundary; it overrides the busy clear above.
        if (bus.div_load) begin
          pend_d = bus.div_val;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clk_out_d = (state_d == ST_HIGH);
    rise_d    = (state_d == ST_HIGH) && (state_q != ST_HIGH);
    fall_d    = (state_q == ST_HIGH) && (state_d != ST_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      active_div_q <= CNT_W'(DEF_DIV);
      pend_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      clk_out_q    <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_div_q <= active_div_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      clk_out_q    <= clk_out_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
    end
  end

  assign bus.clk_out    = clk_out_q;
  assign bus.rise_stb   = rise_q;
  assign bus.fall_stb   = fall_q;
  assign bus.div_busy   = busy_q;
  assign bus.div_done   = done_q;
  assign bus.active_div = active_div_q;

endmodule

// File: tb/tb_clk_div_switch.sv
// Self-checking bench for clk_div_switch. The reference model works on whole
// periods: at each period boundary it queues the complete waveform of the
// next period, and every cycle pops one sample.
module tb_clk_div_switch;

  localparam int CNT_W = 8;
  localparam int DEF   = 1;

  typedef struct packed {
    logic             clk_out;
    logic             rise;
    logic             fall;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] active;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_div_switch_if #(.CNT_W(CNT_W)) bus ();

  clk_div_switch #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  bit m_q[$];
  bit m_running, m_clk, m_prev, m_done, m_pend_v;
  int m_active, m_pend;

  task automatic model_reset();
    m_q.delete();
    m_running = 0; m_clk = 0; m_prev = 0; m_done = 0;
    m_pend_v = 0; m_pend = 0; m_active = DEF;
  endtask

  task automatic model_step(input bit en, input bit load, input int val);
    bit boundary;
    boundary = (m_q.size() == 0);
    m_done = 0;
    m_prev = m_clk;
    if (boundary) begin
      if (!m_running && load) begin
        m_active = val; m_pend_v = 0; m_done = 1;
      end else begin
        if (m_pend_v) begin
          m_active = m_pend; m_pend_v = 0; m_done = 1;
        end
        if (load) begin
          m_pend = val; m_pend_v = 1;
        end
      end
      if (en) begin
        for (int k = 0; k <= m_active; k++) m_q.push_back(1'b1);
        for (int k = 0; k <= m_active; k++) m_q.push_back(1'b0);
      end
    end else if (load) begin
      m_pend = val; m_pend_v = 1;
    end
    if (m_q.size() > 0) begin
      m_clk = m_q.pop_front(); m_running = 1;
    end else begin
      m_clk = 0; m_running = 0;
    end
  endtask

  function automatic obs_t get_exp();
    obs_t e;
    e.clk_out = m_clk;
    e.rise    = m_clk && !m_prev;
    e.fall    = !m_clk && m_prev;
    e.busy    = m_pend_v;
    e.done    = m_done;
    e.active  = m_active[CNT_W-1:0];
    return e;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o.clk_out = bus.clk_out;
    o.rise    = bus.rise_stb;
    o.fall    = bus.fall_stb;
    o.busy    = bus.div_busy;
    o.done    = bus.div_done;
    o.active  = bus.active_div;
    return o;
  endfunction

  // One clock: drive inputs, step the model on the edge, settle for sampling.
  task automatic cycle(input bit en, input bit load, input int val);
    bus.en       = en;
    bus.div_load = load;
    bus.div_val  = val[CNT_W-1:0];
    @(posedge clk);
    model_step(en, load, val);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.en = 0; bus.div_load = 0; bus.div_val = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (get_obs() !== get_exp()) begin
      miscompares++;
      $display("FAIL reset got=%h want=%h", get_obs(), get_exp());
    end
    @(negedge clk);
    rst_n = 1;
    $display("reset released, active_div=%0d", bus.active_div);
  endtask

  task automatic goto_idle(input string name);
    int n = 0;
    while (m_running || m_q.size() != 0) begin
      cycle(0, 0, 0);
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL %s_idle cyc=%0d got=%h want=%h", name, n, get_obs(), get_exp());
      end
      n++;
      if (n > 600) begin
        miscompares++;
        $display("FAIL %s_idle timeout got=%0d want<=600", name, n);
        break;
      end
    end
  endtask

  task automatic test_default_run();
    for (int i = 0; i < 14; i++) begin
      cycle(1, 0, 0);
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL default_run cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    $display("default run: 14 cycles at div %0d", DEF);
    goto_idle("default");
  endtask

  task automatic test_idle_div0();
    int dones = 0;
    int busies = 0;
    cycle(0, 1, 0);
    dones += bus.div_done; busies += bus.div_busy;
    vectors++;
    if (get_obs() !== get_exp()) begin
      miscompares++;
      $display("FAIL idle_div0_load got=%h want=%h", get_obs(), get_exp());
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      dones += bus.div_done; busies += bus.div_busy;
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL idle_div0 cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    vectors++;
    if (dones !== 1 || busies !== 0) begin
      miscompares++;
      $display("FAIL idle_div0_pulses got done=%0d busy=%0d want done=1 busy=0", dones, busies);
    end
    $display("idle load div=0, clk/2 run");
    goto_idle("div0");
  endtask

  task automatic test_mid_high_load();
    cycle(0, 1, 3);
    for (int i = 0; i < 40; i++) begin
      // Pulse the new value on the second high cycle of the first period.
      bit ld = (i == 2);
      cycle(1, ld, 7);
      if (ld) $display("load div=7 mid-HIGH, busy=%0d", bus.div_busy);
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL mid_high cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    goto_idle("midhigh");
  endtask

  task automatic test_last_wins();
    int dones = 0;
    cycle(0, 1, 2);
    for (int i = 0; i < 30; i++) begin
      bit ld = (i == 1) || (i == 4);
      cycle(1, ld, (i == 1) ? 5 : 1);
      if (i > 0) dones += bus.div_done;
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL last_wins cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    vectors++;
    if (dones !== 1 || bus.active_div !== 8'd1) begin
      miscompares++;
      $display("FAIL last_wins_final got done=%0d div=%0d want done=1 div=1", dones, bus.active_div);
    end
    $display("two loads (5 then 1), active_div=%0d", bus.active_div);
    goto_idle("lastwins");
  endtask

  task automatic test_en_drop();
    int rises = 0;
    cycle(0, 1, 4);
    cycle(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0);
      if (i > 0) rises += bus.rise_stb;
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL en_drop cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    vectors++;
    if (rises !== 0 || bus.clk_out !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop_tail got rises=%0d clk_out=%0d want 0 0", rises, bus.clk_out);
    end
    $display("en dropped on first HIGH cycle at div 4");
    goto_idle("endrop");
  endtask

  task automatic test_load_at_boundary();
    int n = 0;
    cycle(0, 1, 2);
    cycle(1, 0, 0);
    // Advance until the next edge is a period boundary.
    while (!(m_q.size() == 0 && m_running) && n < 50) begin
      cycle(1, 0, 0);
      n++;
    end
    cycle(1, 1, 4);
    $display("load div=4 on boundary cycle after %0d cycles", n);
    vectors++;
    if (get_obs() !== get_exp()) begin
      miscompares++;
      $display("FAIL boundary_load got=%h want=%h", get_obs(), get_exp());
    end
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0, 0);
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL boundary cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    goto_idle("boundary");
  endtask

  task automatic test_max_div();
    cycle(1, 1, 255);
    for (int i = 0; i < 515; i++) begin
      cycle(0, 0, 0);
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL max_div cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    $display("all-ones divide, single 512-cycle period");
    goto_idle("maxdiv");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit en = ($urandom_range(0, 7) != 0);
      bit ld = ($urandom_range(0, 15) == 0);
      int v  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 6);
      cycle(en, ld, v);
      if (ld) $display("random load div=%0d at cyc %0d", v, i);
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
    goto_idle("random");
  endtask

  task automatic test_reset_mid_low();
    int n = 0;
    cycle(0, 1, 3);
    cycle(1, 0, 0);
    cycle(1, 1, 6);
    while (!(m_running && !m_clk) && n < 50) begin
      cycle(1, 0, 0);
      n++;
    end
    cycle(1, 0, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    vectors++;
    if (get_obs() !== get_exp()) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", get_obs(), get_exp());
    end
    @(posedge clk);
    #1;
    vectors++;
    if (get_obs() !== get_exp()) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=%h", get_obs(), get_exp());
    end
    @(negedge clk);
    rst_n = 1;
    $display("reset asserted mid-LOW with pending load");
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      vectors++;
      if (get_obs() !== get_exp()) begin
        miscompares++;
        $display("FAIL post_reset cyc=%0d got=%h want=%h", i, get_obs(), get_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_idle_div0();
    test_mid_high_load();
    test_last_wins();
    test_en_drop();
    test_load_at_boundary();
    test_max_div();
    test_random();
    test_reset_mid_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
